// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Brief    : Mem-stage exception detector and pipeline redirect controller.
//            Prioritises per-instruction exception flags and pending
//            interrupts, pulses the CP0 exception inputs for one cycle and
//            holds a multi-cycle flush with the redirect PC (exception vector,
//            or EPC for ERET).
//            Optional feature macro: CP0_FWD_EN (forward an in-flight MTC0
//            from write-back into the effective Status/Cause/EPC).
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        eret_i,
    input  logic        adel_ld_i,
    input  logic        ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    // Exception codes presented to CP0
    localparam logic [31:0] C_EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] C_EXC_ADEL    = 32'h0000_0004;
    localparam logic [31:0] C_EXC_ADES    = 32'h0000_0005;
    localparam logic [31:0] C_EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] C_EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] C_EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] C_EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] C_EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] C_EXC_ERET    = 32'h0000_000e;

    // Flush counter load value: counter counts the remaining extra cycles
    localparam logic [3:0]  C_FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] excepttype_q;
    logic [31:0] cia_q;
    logic        ds_q;
    logic [31:0] bad_addr_q;
    logic        flush_q;
    logic [31:0] newpc_q;

    logic [31:0] w_status_eff;
    logic [31:0] w_cause_eff;
    logic [31:0] w_epc_eff;
    logic        w_int_pending;
    logic        w_any_src;
    logic        w_detect;
    logic [31:0] code_d;
    logic [31:0] bad_addr_d;
    logic [31:0] newpc_d;

`ifdef CP0_FWD_EN
    // Effective CP0 state: an MTC0 sitting in write-back overrides the CP0 copy
    always_comb begin
        w_status_eff = cp0_status_i;
        w_cause_eff  = cp0_cause_i;
        w_epc_eff    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            if (wb_cp0_waddr_i == 5'd12) begin
                w_status_eff = wb_cp0_wdata_i;
            end
            if (wb_cp0_waddr_i == 5'd13) begin
                // Only the software interrupt bits are writable; IP7..IP2 stay hardware-driven
                w_cause_eff[9:8] = wb_cp0_wdata_i[9:8];
            end
            if (wb_cp0_waddr_i == 5'd14) begin
                w_epc_eff = wb_cp0_wdata_i;
            end
        end
    end
`else
    // Effective CP0 state comes straight from CP0; write-back MTC0 is not forwarded
    always_comb begin
        w_status_eff = cp0_status_i;
        w_cause_eff  = cp0_cause_i;
        w_epc_eff    = cp0_epc_i;
    end
`endif

    // Bits of the CP0 registers and write-back port that carry no meaning here
    logic w_unused;
    assign w_unused = ^{w_status_eff, w_cause_eff, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i};

    // IE set, EXL clear, and at least one unmasked interrupt line
    assign w_int_pending = w_status_eff[0] & ~w_status_eff[1]
                         & (|(w_cause_eff[15:8] & w_status_eff[15:8]));

    // Priority encoder: pick the single highest-priority source and its BadVAddr
    always_comb begin
        code_d     = 32'h0;
        bad_addr_d = 32'h0;
        w_any_src  = 1'b1;
        if (w_int_pending) begin
            code_d = C_EXC_INT;
        end else if (adel_if_i) begin
            code_d     = C_EXC_ADEL;
            bad_addr_d = pc_i;
        end else if (ri_i) begin
            code_d = C_EXC_RI;
        end else if (ov_i) begin
            code_d = C_EXC_OV;
        end else if (trap_i) begin
            code_d = C_EXC_TRAP;
        end else if (syscall_i) begin
            code_d = C_EXC_SYSCALL;
        end else if (break_i) begin
            code_d = C_EXC_BREAK;
        end else if (eret_i) begin
            code_d = C_EXC_ERET;
        end else if (adel_ld_i) begin
            code_d     = C_EXC_ADEL;
            bad_addr_d = mem_addr_i;
        end else if (ades_i) begin
            code_d     = C_EXC_ADES;
            bad_addr_d = mem_addr_i;
        end else begin
            w_any_src = 1'b0;
        end
    end

    // Detection only for a real, moving instruction while not already flushing
    assign w_detect = (state_q == ST_IDLE) & valid_i & ~stall_i & w_any_src;

    // ERET resumes at EPC; every other event enters the general vector
    assign newpc_d = (code_d == C_EXC_ERET) ? w_epc_eff : EXC_VECTOR;

    // Controller FSM with registered CP0 pulse, flush and redirect outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            excepttype_q <= 32'h0;
            cia_q        <= 32'h0;
            ds_q         <= 1'b0;
            bad_addr_q   <= 32'h0;
            flush_q      <= 1'b0;
            newpc_q      <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_detect) begin
                        excepttype_q <= code_d;
                        cia_q        <= pc_i;
                        ds_q         <= is_in_delayslot_i;
                        bad_addr_q   <= bad_addr_d;
                        flush_q      <= 1'b1;
                        newpc_q      <= newpc_d;
                        cnt_q        <= C_FLUSH_LAST;
                        state_q      <= ST_FLUSH;
                    end else begin
                        excepttype_q <= 32'h0;
                        cia_q        <= 32'h0;
                        ds_q         <= 1'b0;
                        bad_addr_q   <= 32'h0;
                        flush_q      <= 1'b0;
                        newpc_q      <= 32'h0;
                    end
                end
                ST_FLUSH: begin
                    // CP0 inputs are a one-cycle pulse; flush and target persist
                    excepttype_q <= 32'h0;
                    cia_q        <= 32'h0;
                    ds_q         <= 1'b0;
                    bad_addr_q   <= 32'h0;
                    if (cnt_q == 4'd0) begin
                        flush_q <= 1'b0;
                        newpc_q <= 32'h0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    flush_q <= 1'b0;
                    newpc_q <= 32'h0;
                end
            endcase
        end
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = cia_q;
    assign is_in_delayslot_o   = ds_q;
    assign bad_addr_o          = bad_addr_q;
    assign flush_o             = flush_q;
    assign newpc_o             = newpc_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_ctrl
// Brief    : Scoreboard bench for exc_ctrl. Each stimulus that should raise
//            an event pushes its expected CP0 pulse and redirect target; a
//            monitor pops and compares on every rising flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    localparam int unsigned C_FLUSH_CYCLES = 2;
    localparam logic [31:0] C_VEC          = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, valid_i, is_in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i;
    logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, eret_i, adel_ld_i, ades_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
    logic        is_in_delayslot_o, flush_o;

    exc_ctrl #(.EXC_VECTOR(C_VEC), .FLUSH_CYCLES(C_FLUSH_CYCLES)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_i             (stall_i),
        .valid_i             (valid_i),
        .pc_i                (pc_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .adel_if_i           (adel_if_i),
        .ri_i                (ri_i),
        .ov_i                (ov_i),
        .trap_i              (trap_i),
        .syscall_i           (syscall_i),
        .break_i             (break_i),
        .eret_i              (eret_i),
        .adel_ld_i           (adel_ld_i),
        .ades_i              (ades_i),
        .mem_addr_i          (mem_addr_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_wdata_i      (wb_cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .newpc_o             (newpc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [31:0] addr;
        logic [31:0] ds;
        logic [31:0] bad;
        logic [31:0] newpc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        prev_flush = 1'b0;
    int          flen = 0;
    logic [31:0] cur_newpc = 32'h0;
    logic        rst_in_flush = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: compare each rising flush against the scoreboard, then police the flush window
    always @(negedge clk) begin
        exp_t e;
        if (flush_o && !prev_flush) begin
            if (sb_q.size() == 0) begin
                check("unexpected_event", {31'h0, flush_o}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("excepttype", excepttype_o, e.code);
                check("cur_inst_addr", current_inst_addr_o, e.addr);
                check("delayslot", {31'h0, is_in_delayslot_o}, e.ds);
                check("bad_addr", bad_addr_o, e.bad);
                check("newpc", newpc_o, e.newpc);
                cur_newpc = e.newpc;
            end
            flen = 1;
        end else if (flush_o) begin
            flen++;
            check("excepttype_clr", excepttype_o, 32'h0);
            check("cia_clr", current_inst_addr_o, 32'h0);
            check("bad_addr_clr", bad_addr_o, 32'h0);
            check("newpc_hold", newpc_o, cur_newpc);
        end else if (prev_flush) begin
            if (!rst_in_flush) check("flush_len", flen, C_FLUSH_CYCLES);
            check("newpc_clr", newpc_o, 32'h0);
        end
        prev_flush = flush_o;
    end

    task automatic clear_inputs();
        stall_i = 0; valid_i = 0; is_in_delayslot_i = 0; pc_i = 0; mem_addr_i = 0;
        adel_if_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0; break_i = 0;
        eret_i = 0; adel_ld_i = 0; ades_i = 0;
        cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        wb_cp0_we_i = 0; wb_cp0_waddr_i = 0; wb_cp0_wdata_i = 0;
    endtask

    task automatic push_exp(input logic [31:0] code, input logic [31:0] addr, input logic ds,
                            input logic [31:0] bad, input logic [31:0] npc);
        exp_t e;
        e.code = code; e.addr = addr; e.ds = {31'h0, ds}; e.bad = bad; e.newpc = npc;
        sb_q.push_back(e);
    endtask

    // Present the currently set inputs for one cycle, then return them to idle
    task automatic apply_one();
        @(negedge clk);
        clear_inputs();
    endtask

    // Wait (bounded) for the flush window to close and the scoreboard to drain
    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!flush_o) break;
        end
        if (i == 40) check("timeout_flush", {31'h0, flush_o}, 32'h0);
        check("sb_drained", sb_q.size(), 32'h0);
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        quiet(3);
        rst = 1'b0;
        check("rst_excepttype", excepttype_o, 32'h0);
        check("rst_flush", {31'h0, flush_o}, 32'h0);
        check("rst_newpc", newpc_o, 32'h0);
        check("rst_bad_addr", bad_addr_o, 32'h0);

        // SYSCALL
        valid_i = 1; syscall_i = 1; pc_i = 32'hBFC00100;
        push_exp(32'h8, 32'hBFC00100, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // Overflow beats syscall and store error, delay slot reported
        valid_i = 1; ov_i = 1; syscall_i = 1; ades_i = 1; is_in_delayslot_i = 1;
        pc_i = 32'h80001000; mem_addr_i = 32'h12345678;
        push_exp(32'hc, 32'h80001000, 1'b1, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // Interrupt beats reserved instruction
        valid_i = 1; ri_i = 1; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
        pc_i = 32'h80002000;
        push_exp(32'h1, 32'h80002000, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // EXL set masks the interrupt
        valid_i = 1; ri_i = 1; cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h00000400;
        pc_i = 32'h80002004;
        push_exp(32'ha, 32'h80002004, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // Stalled: interrupt stays pending until the stall drops
        valid_i = 1; ri_i = 1; stall_i = 1; cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00000400;
        pc_i = 32'h80002008;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_noflush", {31'h0, flush_o}, 32'h0);
        end
        stall_i = 0;
        push_exp(32'h1, 32'h80002008, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // valid_i low: nothing happens
        syscall_i = 1; pc_i = 32'h80003000;
        quiet(2);
        check("invalid_noflush", {31'h0, flush_o}, 32'h0);
        clear_inputs();

        // ERET redirect to EPC, with an MTC0 to EPC in write-back
        valid_i = 1; eret_i = 1; cp0_epc_i = 32'hBFC01234; pc_i = 32'h80004000;
        wb_cp0_we_i = 1; wb_cp0_waddr_i = 5'd14; wb_cp0_wdata_i = 32'h80000010;
`ifdef CP0_FWD_EN
        push_exp(32'he, 32'h80004000, 1'b0, 32'h0, 32'h80000010);
`else
        push_exp(32'he, 32'h80004000, 1'b0, 32'h0, 32'hBFC01234);
`endif
        apply_one();
        wait_idle();

        // Load address error, second flag during FLUSH ignored
        valid_i = 1; adel_ld_i = 1; mem_addr_i = 32'h00000003; pc_i = 32'h80005000;
        push_exp(32'h4, 32'h80005000, 1'b0, 32'h00000003, C_VEC);
        apply_one();
        valid_i = 1; ri_i = 1; pc_i = 32'h80005004;
        apply_one();
        wait_idle();
        quiet(3);

        // Fetch address error reports PC as bad address; back-to-back with break
        valid_i = 1; adel_if_i = 1; break_i = 1; pc_i = 32'h80006001;
        push_exp(32'h4, 32'h80006001, 1'b0, 32'h80006001, C_VEC);
        apply_one();
        wait_idle();
        valid_i = 1; break_i = 1; pc_i = 32'h80006010;
        push_exp(32'h9, 32'h80006010, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // Trap
        valid_i = 1; trap_i = 1; ades_i = 1; pc_i = 32'h80007000; mem_addr_i = 32'h7;
        push_exp(32'hd, 32'h80007000, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();

        // Store address error alone
        valid_i = 1; ades_i = 1; pc_i = 32'h80007100; mem_addr_i = 32'h80007102;
        push_exp(32'h5, 32'h80007100, 1'b0, 32'h80007102, C_VEC);
        apply_one();
        wait_idle();

        // Reset during FLUSH
        valid_i = 1; syscall_i = 1; pc_i = 32'h80008000;
        push_exp(32'h8, 32'h80008000, 1'b0, 32'h0, C_VEC);
        apply_one();
        rst_in_flush = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_flush_mid", {31'h0, flush_o}, 32'h0);
        check("rst_newpc_mid", newpc_o, 32'h0);
        check("rst_exc_mid", excepttype_o, 32'h0);
        @(negedge clk);
        rst_in_flush = 1'b0;

        // Fresh syscall after reset
        valid_i = 1; syscall_i = 1; pc_i = 32'hBFC00200;
        push_exp(32'h8, 32'hBFC00200, 1'b0, 32'h0, C_VEC);
        apply_one();
        wait_idle();
        quiet(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Mem-stage exception detector and pipeline redirect controller for the MIPS core.
- Collects per-instruction exception flags and pending interrupts, and prioritises them.
- Drives the CP0 exception inputs (excepttype, current instruction address, delay-slot flag, bad address) as a registered one-cycle pulse.
- Asserts a multi-cycle pipeline flush with the redirect PC: the exception vector, or EPC for ERET.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception entry PC.
- FLUSH_CYCLES, 2, cycles flush_o stays high per event; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_i  in  1  mem stage held this cycle
- valid_i  in  1  mem stage holds a real instruction
- pc_i  in  32  mem-stage instruction PC
- is_in_delayslot_i  in  1  instruction is in a branch delay slot
- adel_if_i  in  1  fetch address error
- ri_i  in  1  reserved instruction
- ov_i  in  1  arithmetic overflow
- trap_i  in  1  trap taken
- syscall_i  in  1  SYSCALL
- break_i  in  1  BREAK
- eret_i  in  1  ERET
- adel_ld_i  in  1  load address error
- ades_i  in  1  store address error
- mem_addr_i  in  32  data access address
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  MTC0 in write-back (used only with CP0_FWD_EN)
- wb_cp0_waddr_i  in  5  MTC0 register number
- wb_cp0_wdata_i  in  32  MTC0 data
- excepttype_o  out  32  exception code to CP0
- current_inst_addr_o  out  32  faulting PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- bad_addr_o  out  32  BadVAddr value to CP0
- flush_o  out  1  flush all pipeline stages
- newpc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Reset: all outputs 0; state IDLE; flush counter 0. Reset asserted in any state returns to IDLE the next cycle with all outputs 0.
- Detection is combinational on effective Status/Cause/EPC. It is enabled only when state=IDLE, valid_i=1 and stall_i=0.
- Interrupt pending: Status[0]=1 AND Status[1]=0 AND (Cause[15:8] & Status[15:8])!=0.
- Priority, highest first, with excepttype code:
  - interrupt 0x1
  - adel_if 0x4
  - ri 0xa
  - ov 0xc
  - trap 0xd
  - syscall 0x8
  - break 0x9
  - eret 0xe
  - adel_ld 0x4
  - ades 0x5
- Only the highest-priority source is reported.
- bad_addr:
  - adel_if: pc_i
  - adel_ld/ades: mem_addr_i
  - all other codes: 0
- On detection, at the next clock edge:
  - excepttype_o = code; current_inst_addr_o = pc_i; is_in_delayslot_o = is_in_delayslot_i; bad_addr_o set as above.
  - flush_o = 1.
  - newpc_o = effective EPC for 0xe, else EXC_VECTOR.
  - State -> FLUSH; counter = FLUSH_CYCLES-1.
- FLUSH state:
  - excepttype_o returns to 0 after exactly one cycle; current_inst_addr_o, is_in_delayslot_o and bad_addr_o also return to 0.
  - flush_o and newpc_o are held.
  - Counter decrements every cycle regardless of stall_i. At 0 the next cycle drops flush_o, clears newpc_o to 0, and returns to IDLE.
  - All inputs are ignored in FLUSH; no new detection.
- Back-to-back: the cycle after FLUSH ends, IDLE may detect again. With FLUSH_CYCLES=1, flush_o is high for exactly one cycle and detection resumes the following cycle.
- valid_i=0 or stall_i=1: no event, even if flags or an interrupt are pending. The interrupt stays pending (level-sensitive) and is taken on the first valid, unstalled cycle.
- No event in IDLE: excepttype_o = 0, flush_o = 0.

Optional Feature:
- Macro: CP0_FWD_EN.
- Defined: the effective Status/Cause/EPC replace the CP0 input with wb_cp0_wdata_i when wb_cp0_we_i=1 and wb_cp0_waddr_i equals 12 (Status) / 14 (EPC) respectively. For Cause (13), only bits 9:8 are replaced; IP7..IP2 still come from cp0_cause_i.
- Undefined: cp0_*_i are used directly and the wb_cp0_* ports are ignored.

Test Plan:
- Reset, then SYSCALL (valid_i=1, syscall_i=1, pc_i=0xBFC00100, is_in_delayslot_i=0) -> next cycle:
  - excepttype_o=0x8, current_inst_addr_o=0xBFC00100, newpc_o=0xBFC00380, flush_o=1.
  - excepttype_o returns to 0 one cycle later; flush_o stays high for 2 cycles total.
- ov_i, syscall_i and ades_i asserted together with is_in_delayslot_i=1 -> excepttype_o=0xc, is_in_delayslot_o=1, bad_addr_o=0.
- Status=0x0000FF01, Cause[10]=1, ri_i=1 -> excepttype_o=0x1.
  - Same with Status[1]=1 -> excepttype_o=0xa.
  - Same with stall_i=1 -> no event until stall_i drops.
- eret_i=1 with cp0_epc_i=0xBFC01234 -> excepttype_o=0xe, newpc_o=0xBFC01234.
  - With CP0_FWD_EN and an MTC0 to reg 14 of 0x80000010 in the same cycle -> newpc_o=0x80000010.
- adel_ld_i=1, mem_addr_i=0x00000003 -> excepttype_o=0x4, bad_addr_o=0x00000003.
  - A second flag asserted during FLUSH is ignored.
- Reset asserted during FLUSH -> the next cycle flush_o=0, newpc_o=0, state IDLE; a fresh syscall is then detected normally.
